sd_stream_packer: RTL and testbench
===================================

// Module: sd_stream_packer
// PURPOSE
//  Packs the SD file-reader byte stream (one byte per request strobe, no backpressure)
//  into WORD_BYTES-wide sample words and buffers them in a FIFO.
//  Delivers the words on a valid/ready interface to the modulation-recognition datapath.
//  Words are tagged round-robin with a channel index (e.g. I/Q interleave); a flush
//  input closes a partial word at end of file.
// PARAMETERS
//  WORD_BYTES  4   bytes per output word, >=1; out_data width = 8*WORD_BYTES
//  BIG_ENDIAN  1   1: first byte -> out_data MSByte; 0: first byte -> LSByte
//  FIFO_DEPTH  16  word FIFO entries, power of 2, >=2
//  NUM_CH      2   channel tags, >=1; CH_W = max(1,$clog2(NUM_CH))
// PORTS
//  clk         in   1              system clock
//  rst         in   1              async active-high reset
//  in_valid    in   1              byte strobe from SD reader (outreq)
//  in_byte     in   8              byte data (outbyte)
//  flush       in   1              pulse: emit partial word zero-padded, restart channel at 0
//  out_valid   out  1              FIFO head word valid
//  out_ready   in   1              consumer accepts head word when out_valid&&out_ready
//  out_data    out  8*WORD_BYTES   packed word
//  out_ch      out  CH_W           channel tag of head word
//  out_last    out  1              head word was produced by flush
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words held
//  overflow    out  1              sticky: a completed word was dropped on full FIFO
//  drop_cnt    out  16             dropped words, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, while rst=1): byte index, channel counter, FIFO pointers cleared;
//   out_valid=0, out_data=0, out_ch=0, out_last=0, fifo_level=0, overflow=0, drop_cnt=0.
//   Reset mid-word discards the partial word; mid-FIFO discards all stored words.
//  Packing: byte index k counts 0..WORD_BYTES-1; each in_valid writes in_byte to lane k
//   (lane k = bits [8*(WORD_BYTES-1-k)+:8] if BIG_ENDIAN else [8*k+:8]).
//   When in_valid with k=WORD_BYTES-1, the completed word + current channel tag are pushed,
//   k->0, channel->(ch==NUM_CH-1 ? 0 : ch+1).
//  Flush: in cycle with flush=1, the byte in that cycle (if in_valid) is packed first.
//   If the resulting partial word has >=1 byte, it is pushed with unfilled lanes=0 and
//   last=1. If the byte completes a word, that word is pushed with last=1 (one push only).
//   If k=0 and no byte, nothing is pushed. After flush: k=0, channel=0.
//  Latency: word pushed at clock edge ending cycle N is visible at the head (out_valid=1)
//   in cycle N+1 when the FIFO was empty. Show-ahead FIFO; head is registered.
//  Handshake: out_data/out_ch/out_last hold stable while out_valid&&!out_ready.
//   Pop on out_valid&&out_ready; the next entry appears in the following cycle, no bubble
//   when level>1.
//  Full: push with level==FIFO_DEPTH and no pop in same cycle -> word dropped, overflow
//   set (cleared only by rst), drop_cnt+1. The channel counter still advances, keeping
//   the I/Q phase.
//  Push and pop in the same cycle: both happen, level unchanged, including when full
//   (no drop). Empty: pop impossible since out_valid=0.
//  fifo_level: updated at edge: +1 push only, -1 pop only, unchanged otherwise.
//  Pointers wrap modulo FIFO_DEPTH; a full/empty distinction uses an extra pointer bit.
//  No combinational path from in_* to out_*; out_ready may be combinational to FIFO pop
//   only.
// TESTING
//  1 Defaults, bytes 11,22,33,44,55,66,77,88 back-to-back, out_ready=1 -> words
//    32'h11223344 ch0, 32'h55667788 ch1, out_valid one cycle after 4th/8th byte.
//  2 BIG_ENDIAN=0, same bytes -> 32'h44332211, 32'h88776655.
//  3 Bytes AA,BB then flush with in_valid byte CC -> 32'hAABBCC00, last=1, ch0;
//    the next 4 bytes form a ch0 word.
//  4 out_ready=0, 17 words streamed -> level=16, 17th dropped, overflow=1, drop_cnt=1;
//    drain yields 16 words, ch tags alternating 0,1.
//  5 Full FIFO, out_ready=1 in the cycle a word completes -> no drop, level stays 16.
//  6 Assert rst after 2 bytes of a word and with 3 words queued -> all outputs 0;
//    next 4 bytes give a fresh ch0 word.

Source files
------------

// File: rtl/sd_stream_packer.sv
// Packs a byte stream into WORD_BYTES-wide words tagged round-robin by channel, buffered in a show-ahead FIFO.
// Latency: a completed word reaches the registered head one cycle after its last byte; no backpressure upstream, words dropped when full.
module sd_stream_packer #(
    parameter int WORD_BYTES = 4,
    parameter int BIG_ENDIAN = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int NUM_CH     = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW        = 8 * WORD_BYTES,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [7:0]      in_byte,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [CH_W-1:0] out_ch,
    output logic            out_last,
    output logic [LW-1:0]   fifo_level,
    output logic            overflow,
    output logic [15:0]     drop_cnt
);

    localparam int KW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic            last;
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   data;
    } entry_t;

    function automatic int lane_lsb(input int lane);
        return (BIG_ENDIAN != 0) ? 8 * (WORD_BYTES - 1 - lane) : 8 * lane;
    endfunction

    // ---------------- byte packer ----------------
    logic [KW-1:0]   byte_idx;
    logic [CH_W-1:0] ch_cnt;
    logic [CH_W-1:0] ch_next;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   word_cur;
    logic            word_done;
    logic            push_req;
    entry_t          push_ent;

    // acc keeps unfilled lanes at zero, so a flushed partial word is already padded
    always_comb begin
        word_cur = acc;
        if (in_valid) begin
            for (int l = 0; l < WORD_BYTES; l++) begin
                if (byte_idx == KW'(l)) begin
                    word_cur[lane_lsb(l) +: 8] = in_byte;
                end
            end
        end
    end

    assign word_done = in_valid && (byte_idx == KW'(WORD_BYTES - 1));
    assign push_req  = word_done || (flush && (in_valid || (byte_idx != '0)));
    assign ch_next   = (ch_cnt == CH_W'(NUM_CH - 1)) ? '0 : ch_cnt + 1'b1;
    assign push_ent  = '{last: flush, ch: ch_cnt, data: word_cur};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= '0;
            ch_cnt   <= '0;
            acc      <= '0;
        end else if (flush) begin
            byte_idx <= '0;
            ch_cnt   <= '0;
            acc      <= '0;
        end else if (in_valid) begin
            if (word_done) begin
                byte_idx <= '0;
                acc      <= '0;
                // advances even if the FIFO drops the word, so the I/Q phase survives overflow
                ch_cnt   <= ch_next;
            end else begin
                byte_idx <= byte_idx + 1'b1;
                acc      <= word_cur;
            end
        end
    end

    // ---------------- word FIFO with registered head ----------------
    entry_t        mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_nxt;
    logic [AW:0]   wr_nxt;
    logic          pop;
    logic          full;
    logic          do_push;
    logic          drop;
    logic          head_vld_nxt;
    entry_t        head_src;

    assign fifo_level   = wr_ptr - rd_ptr;
    assign pop          = out_valid && out_ready;
    assign full         = (fifo_level == LW'(FIFO_DEPTH));
    assign do_push      = push_req && (!full || pop);
    assign drop         = push_req && !do_push;
    assign rd_nxt       = rd_ptr + {{AW{1'b0}}, pop};
    assign wr_nxt       = wr_ptr + {{AW{1'b0}}, do_push};
    assign head_vld_nxt = (wr_nxt != rd_nxt);

    // The incoming word bypasses memory when it becomes the head straight away
    always_comb begin
        if (do_push && (wr_ptr == rd_nxt)) begin
            head_src = push_ent;
        end else begin
            head_src = mem[rd_nxt[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            out_valid <= head_vld_nxt;
            if (head_vld_nxt) begin
                out_data <= head_src.data;
                out_ch   <= head_src.ch;
                out_last <= head_src.last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sd_stream_packer.sv
// Bench for sd_stream_packer: directed scenarios plus randomized traffic against a queue-based word model.
module tb_sd_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        flush;
    logic        out_ready;

    logic        out_valid,  le_out_valid;
    logic [31:0] out_data,   le_out_data;
    logic [0:0]  out_ch,     le_out_ch;
    logic        out_last,   le_out_last;
    logic [4:0]  fifo_level, le_fifo_level;
    logic        overflow,   le_overflow;
    logic [15:0] drop_cnt,   le_drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sd_stream_packer u_be (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    sd_stream_packer #(.BIG_ENDIAN(0)) u_le (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .flush(flush),
        .out_valid(le_out_valid), .out_ready(out_ready), .out_data(le_out_data), .out_ch(le_out_ch),
        .out_last(le_out_last), .fifo_level(le_fifo_level), .overflow(le_overflow), .drop_cnt(le_drop_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] be;
        logic [31:0] le;
        int          ch;
        bit          last;
    } exp_t;

    exp_t       mq[$];
    logic [7:0] pb[$];
    int         mch;
    bit         movf;
    int         mdrops;

    task automatic model_reset();
        mq.delete();
        pb.delete();
        mch = 0;
        movf = 0;
        mdrops = 0;
    endtask

    // One clock: apply inputs, advance the model at the edge, return 1 time unit later
    task automatic drive(input bit v, input logic [7:0] b, input bit f, input bit r);
        exp_t e;
        bit   pop;
        bit   push;
        in_valid = v;
        in_byte = b;
        flush = f;
        out_ready = r;
        @(posedge clk);
        pop = (mq.size() > 0) && r;
        push = 0;
        if (v) pb.push_back(b);
        if (pb.size() == 4 || (f && pb.size() > 0)) begin
            e.be = 0;
            e.le = 0;
            for (int i = 0; i < pb.size(); i++) begin
                e.be |= 32'(pb[i]) << (8 * (3 - i));
                e.le |= 32'(pb[i]) << (8 * i);
            end
            e.ch = mch;
            e.last = f;
            push = 1;
            pb.delete();
            mch = (mch + 1) % 2;
        end
        if (f) mch = 0;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < 16) mq.push_back(e);
            else begin
                movf = 1;
                if (mdrops < 65535) mdrops++;
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit ready_last);
        drive(1, w[31:24], 0, 0);
        drive(1, w[23:16], 0, 0);
        drive(1, w[15:8], 0, 0);
        drive(1, w[7:0], 0, ready_last);
    endtask

    task automatic do_reset();
        in_valid = 0; in_byte = 0; flush = 0; out_ready = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        in_valid = 0; in_byte = 0; flush = 0; out_ready = 0;
        rst = 0;
        #1;
        rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (out_ch !== 1'b0) begin failures++; $display("FAIL reset_ch got=%b exp=0", out_ch); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_pack();
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            drive(1, bytes[i], 0, 1);
            if (i == 2) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_early_valid got=%b exp=0", out_valid); end
            end
            if (i == 3) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_w0_valid got=%b exp=1", out_valid); end
                checks++; if (out_data !== 32'h11223344) begin failures++; $display("FAIL pack_w0_be got=%h exp=11223344", out_data); end
                checks++; if (le_out_data !== 32'h44332211) begin failures++; $display("FAIL pack_w0_le got=%h exp=44332211", le_out_data); end
                checks++; if (out_ch !== 1'b0) begin failures++; $display("FAIL pack_w0_ch got=%b exp=0", out_ch); end
            end
            if (i == 7) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pack_w1_valid got=%b exp=1", out_valid); end
                checks++; if (out_data !== 32'h55667788) begin failures++; $display("FAIL pack_w1_be got=%h exp=55667788", out_data); end
                checks++; if (le_out_data !== 32'h88776655) begin failures++; $display("FAIL pack_w1_le got=%h exp=88776655", le_out_data); end
                checks++; if (out_ch !== 1'b1) begin failures++; $display("FAIL pack_w1_ch got=%b exp=1", out_ch); end
            end
        end
        drive(0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pack_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1, 8'hAA, 0, 0);
        drive(1, 8'hBB, 0, 0);
        drive(1, 8'hCC, 1, 0);
        checks++; if (out_data !== 32'hAABBCC00) begin failures++; $display("FAIL flush_be got=%h exp=AABBCC00", out_data); end
        checks++; if (le_out_data !== 32'h00CCBBAA) begin failures++; $display("FAIL flush_le got=%h exp=00CCBBAA", le_out_data); end
        checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL flush_last got=%b exp=1", out_last); end
        checks++; if (out_ch !== 1'b0) begin failures++; $display("FAIL flush_ch got=%b exp=0", out_ch); end
        send_word(32'h01020304, 0);
        drive(0, 0, 1, 0);
        checks++; if (fifo_level !== 5'd2) begin failures++; $display("FAIL flush_empty_level got=%0d exp=2", fifo_level); end
        drive(0, 0, 0, 1);
        checks++; if (out_data !== 32'h01020304) begin failures++; $display("FAIL flush_next_data got=%h exp=01020304", out_data); end
        checks++; if (out_ch !== 1'b0) begin failures++; $display("FAIL flush_next_ch got=%b exp=0", out_ch); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL flush_next_last got=%b exp=0", out_last); end
        drive(0, 0, 0, 1);
        // flush on the byte that completes a word: one push, marked last
        drive(1, 8'h05, 0, 0);
        drive(1, 8'h06, 0, 0);
        drive(1, 8'h07, 0, 0);
        drive(1, 8'h08, 1, 0);
        checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL flush_full_level got=%0d exp=1", fifo_level); end
        checks++; if (out_data !== 32'h05060708 || out_last !== 1'b1) begin failures++; $display("FAIL flush_full_word got=%h/%b exp=05060708/1", out_data, out_last); end
        send_word(32'h090A0B0C, 0);
        drive(0, 0, 0, 1);
        checks++; if (out_ch !== 1'b0) begin failures++; $display("FAIL flush_restart_ch got=%b exp=0", out_ch); end
        drive(0, 0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int w = 0; w < 17; w++) send_word($urandom, 0);
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (out_valid !== 1'b1 || out_ch !== 1'(i % 2)) begin failures++; $display("FAIL ovf_drain_ch[%0d] got=%b/%b exp=1/%0d", i, out_valid, out_ch, i % 2); end
            checks++; if (out_data !== mq[0].be) begin failures++; $display("FAIL ovf_drain_data[%0d] got=%h exp=%h", i, out_data, mq[0].be); end
            drive(0, 0, 0, 1);
        end
        checks++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin failures++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", out_valid, fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int w = 0; w < 16; w++) send_word($urandom, 0);
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL fullpop_pre_level got=%0d exp=16", fifo_level); end
        send_word(32'hDEADBEEF, 1);
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL fullpop_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL fullpop_nodrop got=%b/%0d exp=0/0", overflow, drop_cnt); end
        checks++; if (out_ch !== 1'b1 || out_data !== mq[0].be) begin failures++; $display("FAIL fullpop_head got=%b/%h exp=1/%h", out_ch, out_data, mq[0].be); end
        while (mq.size() > 0) begin
            checks++; if (out_data !== mq[0].be || le_out_data !== mq[0].le) begin failures++; $display("FAIL fullpop_drain got=%h/%h exp=%h/%h", out_data, le_out_data, mq[0].be, mq[0].le); end
            drive(0, 0, 0, 1);
        end
        checks++; if (mq.size() != 0 || out_data !== 32'hDEADBEEF) begin failures++; $display("FAIL fullpop_tail got=%h exp=DEADBEEF", out_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int w = 0; w < 3; w++) send_word($urandom, 0);
        drive(1, 8'hE1, 0, 0);
        drive(1, 8'hE2, 0, 0);
        rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 1'b0 || out_last !== 1'b0) begin failures++; $display("FAIL rstmid_head got=%b/%h/%b/%b exp=0/0/0/0", out_valid, out_data, out_ch, out_last); end
        checks++; if (fifo_level !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_status got=%0d/%b/%0d exp=0/0/0", fifo_level, overflow, drop_cnt); end
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        send_word(32'h5A6B7C8D, 0);
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A6B7C8D || out_ch !== 1'b0) begin failures++; $display("FAIL rstmid_fresh got=%b/%h/%b exp=1/5A6B7C8D/0", out_valid, out_data, out_ch); end
        checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL rstmid_level got=%0d exp=1", fifo_level); end
    endtask

    task automatic test_random();
        int rdy_max;
        do_reset();
        for (int cyc = 0; cyc < 700; cyc++) begin
            rdy_max = (cyc < 300) ? 1 : 7;
            if (cyc >= 640) drive(0, 0, 0, 1);
            else drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
                       $urandom_range(0, rdy_max) == 0);
            checks++; if (out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%0d", cyc, out_valid, mq.size() > 0); end
            checks++; if (fifo_level !== 5'(mq.size())) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, mq.size()); end
            checks++; if (overflow !== movf || drop_cnt !== 16'(mdrops)) begin failures++; $display("FAIL rand_drop cyc=%0d got=%b/%0d exp=%b/%0d", cyc, overflow, drop_cnt, movf, mdrops); end
            if (mq.size() > 0) begin
                checks++; if (out_data !== mq[0].be || le_out_data !== mq[0].le) begin failures++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h/%h", cyc, out_data, le_out_data, mq[0].be, mq[0].le); end
                checks++; if (out_ch !== 1'(mq[0].ch) || out_last !== mq[0].last) begin failures++; $display("FAIL rand_tag cyc=%0d got=%b/%b exp=%0d/%b", cyc, out_ch, out_last, mq[0].ch, mq[0].last); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_flush();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
